// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK counter register: mode field width and
// mode encodings used by the top level and by the testbench.
package jk_counter_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_JK    = 3'b001;
  localparam logic [MODE_W-1:0] MODE_UP    = 3'b010;
  localparam logic [MODE_W-1:0] MODE_DOWN  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b101;
  localparam logic [MODE_W-1:0] MODE_SET   = 3'b110;
  localparam logic [MODE_W-1:0] MODE_RSVD  = 3'b111;

endpackage

// File: rtl/jk_counter_reg_cell.sv
// One-bit JK flip-flop: hold / set / clear / toggle on the rising edge,
// cleared asynchronously while clrn is low.
module jk_cell (
  input  logic clk,
  input  logic clrn,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_reg;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_reg <= 1'b0;
    end else begin
      case ({j, k})
        2'b10:   q_reg <= 1'b1;
        2'b01:   q_reg <= 1'b0;
        2'b11:   q_reg <= ~q_reg;
        default: q_reg <= q_reg;
      endcase
    end
  end

  assign q  = q_reg;
  assign qn = ~q_reg;

endmodule

// File: rtl/jk_counter_reg.sv
// WIDTH-bit register of JK cells with JK, modulo up/down, load, clear and
// set modes. Each cell is steered to a per-bit target value via j/k.
module jk_counter_reg
  import jk_counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              tc,
  output logic              wrap
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] target_next;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             wrap_next;
  logic             wrap_reg;

  // Desired next value of the whole register; the cells are then driven
  // so that each bit lands on its target.
  always_comb begin
    target_next = q_int;
    wrap_next   = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: target_next = q_int;
        MODE_JK:   target_next = (j & ~q_int) | (~k & q_int);
        MODE_UP: begin
          if (q_int >= MAX_COUNT) begin
            target_next = '0;
            wrap_next   = 1'b1;
          end else begin
            target_next = q_int + ONE;
          end
        end
        MODE_DOWN: begin
          if (q_int == '0) begin
            target_next = MAX_COUNT;
            wrap_next   = 1'b1;
          end else begin
            target_next = q_int - ONE;
          end
        end
        MODE_LOAD:  target_next = d;
        MODE_CLEAR: target_next = '0;
        MODE_SET:   target_next = MAX_COUNT;
        MODE_RSVD:  target_next = q_int;
        default:    target_next = q_int;
      endcase
    end
  end

  assign cell_j = target_next & ~q_int;
  assign cell_k = ~target_next & q_int;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk  (clk),
        .clrn (clrn),
        .j    (cell_j[gi]),
        .k    (cell_k[gi]),
        .q    (q_int[gi]),
        .qn   (qn[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= wrap_next;
    end
  end

  // Terminal count looks only at the present state and mode, not en.
  assign tc = ((mode == MODE_UP) && (q_int == MAX_COUNT)) ||
              ((mode == MODE_DOWN) && (q_int == '0));

  assign q    = q_int;
  assign wrap = wrap_reg;

endmodule
